// File: rtl/atm_keypad_frontend_pkg.sv
// Shared definitions for the ATM keypad front end.
//   - Key codes delivered by the keypad scanner (digits are 0-9).
//   - Operation codes presented to the ATM core.
//   - Keypad FSM state encoding, also exported on entry_state.
//   - Width of the BCD PIN fields.
package atm_keypad_frontend_pkg;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam logic [2:0] OP_BALANCE    = 3'd3;
  localparam logic [2:0] OP_WITHDRAW   = 3'd4;
  localparam logic [2:0] OP_DEPOSIT    = 3'd5;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd6;

  // Number of BCD digits in a PIN / new PIN field.
  localparam int unsigned PIN_DIGITS = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAcc    = 3'd1,
    StPin    = 3'd2,
    StOp     = 3'd3,
    StAmt    = 3'd4,
    StNewPin = 3'd5,
    StSend   = 3'd6
  } kp_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/kp_bcd_field.sv
// 4-digit packed BCD shift register used for PIN entry.
// New digits shift in at [3:0]; after four digits the first-entered digit sits in [15:12].
// Loads are ignored once the field is full; clear has priority over load.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   i_load   shift i_digit in (ignored when full)
//   i_digit  BCD digit to shift in
//   i_clear  synchronous clear of value and digit count
//   o_value  packed BCD value
//   o_full   four digits have been entered
module kp_bcd_field
  import atm_keypad_frontend_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [3:0]  i_digit,
  input  logic        i_clear,
  output logic [15:0] o_value,
  output logic        o_full
);

  logic [15:0] r_value;
  logic [2:0]  r_count;
  logic        w_full;

  assign w_full = (r_count == 3'(PIN_DIGITS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_load && !w_full) begin
      r_value <= {r_value[11:0], i_digit};
      r_count <= r_count + 3'd1;
    end
  end

  assign o_value = r_value;
  assign o_full  = w_full;

endmodule

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: turns single-key keypad events into a complete transaction
// request (account, PIN, operation, amount, new PIN, language) and offers it to the
// core over a valid/ready handshake. Handles CLEAR, CANCEL and session timeout so the
// core only ever sees complete requests.
// Build option: define KP_TIMEOUT_EN to enable the idle-session timeout; without it the
// timeout port is tied low and sessions wait indefinitely.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   key_valid      one-cycle strobe qualifying key_code
//   key_code       0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF ignored
//   language_sel   language choice, latched on the session-start ENTER
//   req_ready      core accepts the request
//   req_valid      request complete and held stable
//   acc_num, pin, new_pin, amount, operation, language   request fields
//   busy           session in progress (state != IDLE)
//   timeout        one-cycle pulse when a session is abandoned by timeout
//   entry_state    current FSM state
module atm_keypad_frontend
  import atm_keypad_frontend_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_AMT_DIGITS = 9    // 1..9 keeps amount within 32 bits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        language_sel,
  input  logic        req_ready,
  output logic        req_valid,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] new_pin,
  output logic [31:0] amount,
  output logic [2:0]  operation,
  output logic        language,
  output logic        busy,
  output logic        timeout,
  output logic [2:0]  entry_state
);

  localparam logic [3:0] AmtMaxCnt = 4'(MAX_AMT_DIGITS);

  kp_state_e   r_state, w_state_d;

  logic        w_key_digit, w_key_enter, w_key_clear, w_key_cancel;
  logic        w_in_entry, w_start, w_abort, w_expire;

  logic [3:0]  r_acc, w_acc_d;
  logic        r_acc_filled, w_acc_filled_d;
  logic [31:0] r_amount, w_amount_d;
  logic [3:0]  r_amt_cnt, w_amt_cnt_d;
  logic [2:0]  r_op, w_op_d;
  logic        r_lang, w_lang_d;

  logic        w_pin_clear, w_pin_load, w_pin_full;
  logic        w_npin_clear, w_npin_load, w_npin_full;
  logic [15:0] w_pin_value, w_npin_value;

  // Key decode
  assign w_key_digit  = key_valid && is_digit(key_code);
  assign w_key_enter  = key_valid && (key_code == KEY_ENTER);
  assign w_key_clear  = key_valid && (key_code == KEY_CLEAR);
  assign w_key_cancel = key_valid && (key_code == KEY_CANCEL);

  assign w_in_entry = r_state inside {StAcc, StPin, StOp, StAmt, StNewPin};
  assign w_start    = (r_state == StIdle) && w_key_enter;
  // CANCEL or timeout in an entry state drops the whole session.
  assign w_abort    = w_in_entry && (w_key_cancel || w_expire);

`ifdef KP_TIMEOUT_EN
  localparam int unsigned TcntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TcntW-1:0] r_tcnt, w_tcnt_d;
  logic             r_timeout;

  // A key on the expiry cycle (even an ignored one) wins over the timeout.
  assign w_expire = w_in_entry && !key_valid && (r_tcnt == TcntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_tcnt_d = r_tcnt + 1'b1;
    if (!w_in_entry || key_valid || (w_state_d != r_state)) begin
      w_tcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tcnt    <= w_tcnt_d;
      r_timeout <= w_expire;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign w_expire             = 1'b0;
  assign timeout              = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    if (w_abort) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_key_enter) w_state_d = StAcc;
        end
        StAcc: begin
          if (w_key_enter && r_acc_filled) w_state_d = StPin;
        end
        StPin: begin
          if (w_key_enter && w_pin_full) w_state_d = StOp;
        end
        StOp: begin
          if (w_key_digit) begin
            case (key_code)
              4'd1:       w_state_d = StSend;
              4'd2, 4'd3: w_state_d = StAmt;
              4'd4:       w_state_d = StNewPin;
              default:    w_state_d = r_state;
            endcase
          end
        end
        StAmt: begin
          if (w_key_enter && (r_amount != '0)) w_state_d = StSend;
        end
        StNewPin: begin
          if (w_key_enter && w_npin_full) w_state_d = StSend;
        end
        StSend: begin
          if (req_ready) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    req_valid   = (r_state == StSend);
    busy        = (r_state != StIdle);
    entry_state = r_state;
  end

  // Field next-state. Fields are only touched in entry states, so they stay stable in
  // SEND and after the handshake until the next session-start ENTER.
  always_comb begin
    w_acc_d        = r_acc;
    w_acc_filled_d = r_acc_filled;
    w_amount_d     = r_amount;
    w_amt_cnt_d    = r_amt_cnt;
    w_op_d         = r_op;
    w_lang_d       = r_lang;
    if (w_start || w_abort) begin
      w_acc_d        = '0;
      w_acc_filled_d = 1'b0;
      w_amount_d     = '0;
      w_amt_cnt_d    = '0;
      w_op_d         = '0;
      w_lang_d       = w_start ? language_sel : 1'b0;
    end else begin
      case (r_state)
        StAcc: begin
          if (w_key_clear) begin
            w_acc_d        = '0;
            w_acc_filled_d = 1'b0;
          end else if (w_key_digit) begin
            w_acc_d        = key_code;
            w_acc_filled_d = 1'b1;
          end
        end
        StOp: begin
          if (w_key_clear) begin
            w_op_d = '0;
          end else if (w_key_digit) begin
            case (key_code)
              4'd1:    w_op_d = OP_BALANCE;
              4'd2:    w_op_d = OP_WITHDRAW;
              4'd3:    w_op_d = OP_DEPOSIT;
              4'd4:    w_op_d = OP_CHANGE_PIN;
              default: w_op_d = r_op;
            endcase
          end
        end
        StAmt: begin
          if (w_key_clear) begin
            w_amount_d  = '0;
            w_amt_cnt_d = '0;
          end else if (w_key_digit && (r_amt_cnt < AmtMaxCnt)) begin
            // amount * 10 + digit
            w_amount_d  = (r_amount << 3) + (r_amount << 1) + {28'd0, key_code};
            w_amt_cnt_d = r_amt_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc        <= '0;
      r_acc_filled <= 1'b0;
      r_amount     <= '0;
      r_amt_cnt    <= '0;
      r_op         <= '0;
      r_lang       <= 1'b0;
    end else begin
      r_acc        <= w_acc_d;
      r_acc_filled <= w_acc_filled_d;
      r_amount     <= w_amount_d;
      r_amt_cnt    <= w_amt_cnt_d;
      r_op         <= w_op_d;
      r_lang       <= w_lang_d;
    end
  end

  // PIN and new-PIN fields
  assign w_pin_clear  = w_start || w_abort || ((r_state == StPin) && w_key_clear);
  assign w_pin_load   = (r_state == StPin) && w_key_digit;
  assign w_npin_clear = w_start || w_abort || ((r_state == StNewPin) && w_key_clear);
  assign w_npin_load  = (r_state == StNewPin) && w_key_digit;

  kp_bcd_field u_pin_field (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_pin_load),
    .i_digit (key_code),
    .i_clear (w_pin_clear),
    .o_value (w_pin_value),
    .o_full  (w_pin_full)
  );

  kp_bcd_field u_new_pin_field (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_npin_load),
    .i_digit (key_code),
    .i_clear (w_npin_clear),
    .o_value (w_npin_value),
    .o_full  (w_npin_full)
  );

  assign acc_num   = r_acc;
  assign pin       = w_pin_value;
  assign new_pin   = w_npin_value;
  assign amount    = r_amount;
  assign operation = r_op;
  assign language  = r_lang;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Bench for atm_keypad_frontend: directed session scenarios followed by random keypad
// traffic. A behavioural session model predicts the visible outputs after every clock
// and every completed request; a monitor compares them as the DUT produces them.
module tb_atm_keypad_frontend;

  localparam int T    = 8;
  localparam int MAXD = 9;

  localparam logic [3:0] K_ENT = 4'hA;
  localparam logic [3:0] K_CLR = 4'hB;
  localparam logic [3:0] K_CAN = 4'hC;

  logic        clk, rst;
  logic        key_valid, language_sel, req_ready;
  logic [3:0]  key_code;
  logic        req_valid, language, busy, timeout;
  logic [3:0]  acc_num;
  logic [15:0] pin, new_pin;
  logic [31:0] amount;
  logic [2:0]  operation, entry_state;

  atm_keypad_frontend #(
    .TIMEOUT_CYCLES (T),
    .MAX_AMT_DIGITS (MAXD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .language_sel (language_sel),
    .req_ready    (req_ready),
    .req_valid    (req_valid),
    .acc_num      (acc_num),
    .pin          (pin),
    .new_pin      (new_pin),
    .amount       (amount),
    .operation    (operation),
    .language     (language),
    .busy         (busy),
    .timeout      (timeout),
    .entry_state  (entry_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] npin;
    logic [31:0] amt;
    logic [2:0]  op;
    logic        lang;
    logic        vld;
    logic        busy;
    logic        to;
  } snap_t;

  typedef struct packed {
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] npin;
    logic [31:0] amt;
    logic [2:0]  op;
    logic        lang;
  } req_t;

  snap_t exp_q[$];
  req_t  req_q[$];
  int    tests = 0;
  int    fails = 0;

  // Session model: 0 idle, 1 account, 2 PIN, 3 operation, 4 amount, 5 new PIN, 6 send
  int     m_st;
  int     m_acc;
  bit     m_filled;
  int     m_pin[$];
  int     m_npin[$];
  longint m_amt;
  int     m_amt_n;
  int     m_op;
  bit     m_lang;
  int     m_idle;
  bit     m_to;

  function automatic logic [15:0] pack_digits(input int q[$]);
    int v;
    v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return 16'(v);
  endfunction

  task automatic model_clear_all(input bit lang);
    m_acc    = 0;
    m_filled = 0;
    m_pin.delete();
    m_npin.delete();
    m_amt    = 0;
    m_amt_n  = 0;
    m_op     = 0;
    m_lang   = lang;
  endtask

  task automatic model_reset();
    model_clear_all(1'b0);
    m_st   = 0;
    m_idle = 0;
    m_to   = 0;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st   = 3'(m_st);
    s.acc  = 4'(m_acc);
    s.pin  = pack_digits(m_pin);
    s.npin = pack_digits(m_npin);
    s.amt  = 32'(m_amt);
    s.op   = 3'(m_op);
    s.lang = m_lang;
    s.vld  = (m_st == 6);
    s.busy = (m_st != 0);
    s.to   = m_to;
    return s;
  endfunction

  // Advances the model by one clock with the given inputs and queues the expectation.
  task automatic model_step(input bit kv, input logic [3:0] code, input bit rdy,
                            input bit lsel);
    int   k;
    int   prev;
    req_t r;
    k    = kv ? int'(code) : -1;
    prev = m_st;
    m_to = 0;
    if (m_st == 0) begin
      if (k == 10) begin
        model_clear_all(lsel);
        m_st = 1;
      end
    end else if (m_st == 6) begin
      if (rdy) m_st = 0;
    end else begin
      if (k == 12) begin
        model_clear_all(1'b0);
        m_st = 0;
      end else if (k == 11) begin
        case (m_st)
          1: begin m_acc = 0; m_filled = 0; end
          2: m_pin.delete();
          3: m_op = 0;
          4: begin m_amt = 0; m_amt_n = 0; end
          default: m_npin.delete();
        endcase
      end else if (k >= 0 && k <= 9) begin
        case (m_st)
          1: begin m_acc = k; m_filled = 1; end
          2: if (m_pin.size() < 4) m_pin.push_back(k);
          3: begin
            if (k == 1) begin m_op = 3; m_st = 6; end
            else if (k == 2) begin m_op = 4; m_st = 4; end
            else if (k == 3) begin m_op = 5; m_st = 4; end
            else if (k == 4) begin m_op = 6; m_st = 5; end
          end
          4: if (m_amt_n < MAXD) begin m_amt = m_amt * 10 + k; m_amt_n++; end
          default: if (m_npin.size() < 4) m_npin.push_back(k);
        endcase
      end else if (k == 10) begin
        case (m_st)
          1: if (m_filled) m_st = 2;
          2: if (m_pin.size() == 4) m_st = 3;
          4: if (m_amt != 0) m_st = 6;
          5: if (m_npin.size() == 4) m_st = 6;
          default: ;
        endcase
      end
      if (!kv) begin
        m_idle++;
`ifdef KP_TIMEOUT_EN
        if (m_idle == T) begin
          model_clear_all(1'b0);
          m_st = 0;
          m_to = 1;
        end
`endif
      end
    end
    if (kv || m_st != prev || m_st == 0 || m_st == 6) m_idle = 0;
    if (m_st == 6 && prev != 6) begin
      r.acc  = 4'(m_acc);
      r.pin  = pack_digits(m_pin);
      r.npin = pack_digits(m_npin);
      r.amt  = 32'(m_amt);
      r.op   = 3'(m_op);
      r.lang = m_lang;
      req_q.push_back(r);
    end
    exp_q.push_back(model_snap());
  endtask

  function automatic snap_t read_dut();
    snap_t s;
    s.st   = entry_state;
    s.acc  = acc_num;
    s.pin  = pin;
    s.npin = new_pin;
    s.amt  = amount;
    s.op   = operation;
    s.lang = language;
    s.vld  = req_valid;
    s.busy = busy;
    s.to   = timeout;
    return s;
  endfunction

  // Drives one clock's worth of inputs on the falling edge.
  task automatic cyc(input bit kv, input logic [3:0] code, input bit rdy);
    bit lsel;
    @(negedge clk);
    lsel         = 1'($urandom);
    key_valid    = kv;
    key_code     = kv ? code : 4'($urandom);
    req_ready    = rdy;
    language_sel = lsel;
    model_step(kv, code, rdy, lsel);
  endtask

  task automatic key(input logic [3:0] code);
    cyc(1'b1, code, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, rdy);
  endtask

  task automatic check_reset_outputs(input string name);
    snap_t a;
    a = read_dut();
    tests++;
    if (a !== '0) begin
      fails++;
      $display("FAIL %s got=%h required=0", name, a);
    end
  endtask

  // Monitor: one expected snapshot per clock, one expected request per rising req_valid.
  bit prev_vld = 1'b0;
  initial begin
    snap_t e, a;
    req_t  er, ar;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = read_dut();
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL cycle_state t=%0t got=%h required=%h", $time, a, e);
        end
      end
      if (req_valid === 1'b1 && !prev_vld) begin
        ar = {acc_num, pin, new_pin, amount, operation, language};
        tests++;
        if (req_q.size() == 0) begin
          fails++;
          $display("FAIL request t=%0t got=%h required=none", $time, ar);
        end else begin
          er = req_q.pop_front();
          if (ar !== er) begin
            fails++;
            $display("FAIL request t=%0t got=%h required=%h", $time, ar, er);
          end
        end
      end
      prev_vld = (req_valid === 1'b1);
    end
  end

  initial begin
    int r;
    rst          = 1'b0;
    key_valid    = 1'b0;
    key_code     = 4'h0;
    language_sel = 1'b0;
    req_ready    = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Balance; ready arrives two cycles after the request appears.
    key(K_ENT); key(4'd7); key(K_ENT);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(K_ENT); key(4'd1);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Withdraw with ten 9s: only nine are accepted.
    key(K_ENT); key(4'd3); key(K_ENT);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(K_ENT); key(4'd2);
    for (int i = 0; i < 10; i++) key(4'd9);
    key(K_ENT);
    idle(2, 1'b1);

    // Short PIN, fifth digit, deposit with CLEAR, ignored ENTER, CANCEL.
    key(K_ENT); key(4'd1); key(K_ENT);
    key(4'd1); key(4'd2); key(4'd3); key(K_ENT);
    key(4'd4); key(4'd5); key(K_ENT);
    key(4'd3); key(4'd5); key(4'd0); key(K_CLR); key(K_ENT);
    key(K_CAN);
    idle(1, 1'b0);

    // Idle session, then a key landing exactly on the expiry cycle.
    key(K_ENT);
    idle(T + 2, 1'b0);
    key(K_ENT);
    idle(T - 1, 1'b0);
    key(4'hD);
    idle(2, 1'b0);
    key(K_CAN);

    // Change PIN held in SEND under backpressure with CANCEL/other keys.
    key(K_ENT); key(4'd5); key(K_ENT);
    key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(K_ENT); key(4'd4);
    key(4'd1); key(4'd1); key(4'd2); key(4'd2); key(K_ENT);
    for (int i = 0; i < 20; i++) key((i % 2 == 0) ? K_CAN : 4'(i % 10));
    idle(2, 1'b1);

    // Asynchronous reset in the PIN state.
    key(K_ENT); key(4'd2); key(K_ENT); key(4'd1); key(4'd2);
    @(posedge clk);
    #3;
    key_valid = 1'b0;
    req_ready = 1'b0;
    rst       = 1'b0;
    #1;
    check_reset_outputs("async_reset_in_pin");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random keypad traffic.
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 149) == 0) begin
        idle(T + int'($urandom_range(0, 2)), 1'b0);
      end else if (r < 25) begin
        cyc(1'b0, 4'h0, $urandom_range(0, 3) == 0);
      end else if (r < 40) begin
        cyc(1'b1, 4'($urandom_range(1, 4)), $urandom_range(0, 3) == 0);
      end else if (r < 58) begin
        cyc(1'b1, 4'($urandom_range(0, 9)), $urandom_range(0, 3) == 0);
      end else if (r < 82) begin
        cyc(1'b1, K_ENT, $urandom_range(0, 3) == 0);
      end else if (r < 88) begin
        cyc(1'b1, K_CLR, $urandom_range(0, 3) == 0);
      end else if (r < 90) begin
        cyc(1'b1, K_CAN, $urandom_range(0, 3) == 0);
      end else begin
        cyc(1'b1, 4'($urandom_range(13, 15)), $urandom_range(0, 3) == 0);
      end
    end

    idle(5, 1'b1);
    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_snapshots got=%0d pending required=0", exp_q.size());
    end
    tests++;
    if (req_q.size() != 0) begin
      fails++;
      $display("FAIL drain_requests got=%0d pending required=0", req_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/atm_keypad_frontend.md
Name: atm_keypad_frontend

Overview:
- Upstream entry stage for the ATM core. Collects single-key keypad events into a complete transaction request.
- Request fields: account number, BCD PIN, operation, amount, new PIN, language.
- Presents the request through a valid/ready handshake and holds it stable until accepted.
- Owns session timeout and cancel handling, so the core only ever sees complete requests.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles allowed in an entry state before the session is abandoned.
- MAX_AMT_DIGITS, 9: maximum decimal digits accepted for amount. Legal range 1..9, which guarantees no 32-bit overflow.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF ignored
- language_sel  in  1  language selection, latched at session start
- req_ready  in  1  core accepts the request
- req_valid  out  1  request complete and stable
- acc_num  out  4  account number, 0-9
- pin  out  16  PIN as 4 packed BCD digits; first-entered digit in [15:12]
- new_pin  out  16  new PIN, same packing as pin
- amount  out  32  binary amount
- operation  out  3  operation code
- language  out  1  latched language
- busy  out  1  state != IDLE
- timeout  out  1  one-cycle pulse when a session is abandoned by timeout
- entry_state  out  3  current FSM state encoding

Behaviour:
- Reset (async, rst low): state IDLE; all outputs 0; digit counters and timeout counter 0.
- Timing: keys are sampled on posedge clk when key_valid=1. Each key's effect is visible the following cycle; one key is processed per cycle.
- States: IDLE=0, ACC=1, PIN=2, OP=3, AMT=4, NEWPIN=5, SEND=6.
- IDLE:
  - ENTER: clear all fields, latch language_sel, go to ACC.
  - All other keys ignored.
- ACC:
  - Digit: overwrites acc_num and marks the field filled.
  - ENTER: goes to PIN only if the field is filled; otherwise ignored.
- PIN:
  - Digit: shifts in while fewer than 4 digits; a 5th and later digit is ignored.
  - ENTER: goes to OP only when the count is 4; otherwise ignored.
- OP (digit selects operation):
  - 1 -> operation=3 (BALANCE), go to SEND.
  - 2 -> operation=4 (WITHDRAW), go to AMT.
  - 3 -> operation=5 (DEPOSIT), go to AMT.
  - 4 -> operation=6 (CHANGE_PIN), go to NEWPIN.
  - Other digits and ENTER ignored.
- AMT:
  - Digit: amount <= amount*10 + d while count < MAX_AMT_DIGITS; excess digits ignored.
  - ENTER: goes to SEND only if amount != 0.
- NEWPIN: same rules as PIN, with ENTER at count 4 going to SEND.
- CLEAR (ACC..NEWPIN): zeroes the current field and its digit count; state unchanged.
- CANCEL (ACC..NEWPIN): returns to IDLE; fields are zeroed.
- SEND:
  - req_valid=1; all fields held stable.
  - Transfer completes on a posedge with req_valid & req_ready. Next cycle: IDLE, req_valid=0.
  - Fields keep their values until the next session-start ENTER.
  - All keys, CANCEL and timeout are ignored in SEND; a request is never withdrawn once valid.
- Timeout counter:
  - Runs only in ACC..NEWPIN.
  - Reset to 0 on every sampled key_valid, including ignored keys, and on any state change.
  - When it reaches TIMEOUT_CYCLES-1 with no key: next cycle state=IDLE, fields zeroed, timeout=1 for exactly one cycle.
  - A key arriving in the same cycle as expiry wins; no timeout occurs.
- Reset mid-session: immediate IDLE, no req_valid, no timeout pulse.

Optional Feature:
- Macro: KP_TIMEOUT_EN.
- Defined: timeout counter and timeout pulse behave as described above.
- Undefined: no counter logic; timeout port tied to 0; sessions wait indefinitely.

Decomposition:
- Shared package/defines file holds:
  - key codes: KEY_ENTER, KEY_CLEAR, KEY_CANCEL;
  - operation codes: OP_BALANCE=3, OP_WITHDRAW=4, OP_DEPOSIT=5, OP_CHANGE_PIN=6;
  - keypad FSM state encodings.
- Sub-module: kp_bcd_field, a 4-digit BCD shift register with count, load, clear and full flag. It is instantiated twice, for pin and new_pin.

Test Plan:
- Balance: ENTER,7,ENTER,1,2,3,4,ENTER,1 -> req_valid high the cycle after the last key; acc_num=7, pin=16'h1234, operation=3; req_ready held 2 cycles later -> IDLE, req_valid=0.
- Withdraw with excess digits: ...,2, then 10 digit 9s, ENTER -> amount=999999999, operation=4.
- Short PIN: digits 1,2,3 then ENTER -> stays in PIN. Then 5th-digit test: 4, 5, ENTER -> pin=16'h1234, state OP.
- CLEAR and CANCEL: CLEAR in AMT after 5,0 -> amount=0; ENTER ignored. CANCEL -> IDLE with all fields 0.
- Timeout (KP_TIMEOUT_EN, TIMEOUT_CYCLES=8): enter ACC, apply no keys -> timeout pulse one cycle, IDLE. Repeat with a key on the expiry cycle -> no timeout.
- Backpressure and reset: in SEND with req_ready=0 for 20 cycles plus CANCEL keys -> fields and req_valid stable. Assert rst low in PIN -> all outputs 0 asynchronously.
